// File: rtl/dmem_arbiter_if.sv
// Request/response channel between one requester and the data-memory arbiter.
//   master : requester side (drives request payload and rsp_ready)
//   slave  : arbiter side (drives req_ready and the response)
interface dmem_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;

    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_we;
    logic [CTRL_W-1:0] req_ctrl;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and single-access sequencer for the shared data memory.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   core, dma           : request/response channels (slave side)
//   mem_address, mem_write_data, mem_write_enable, mem_dm_ctrl : to memory
//   mem_read_data       : combinational read data from memory
//   busy                : a transaction is in flight
module dmem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 256,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmem_arbiter_if.slave        core,
    dmem_arbiter_if.slave        dma,
    output logic [31:0]          mem_address,
    output logic [31:0]          mem_write_data,
    output logic                 mem_write_enable,
    output logic [2:0]           mem_dm_ctrl,
    input  logic [31:0]          mem_read_data,
    output logic                 busy
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;
    localparam logic        OWNER_CORE = 1'b0;
    localparam logic        OWNER_DMA  = 1'b1;
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              core_rsp_valid_q, core_rsp_valid_d;
    logic              dma_rsp_valid_q, dma_rsp_valid_d;
    logic              busy_q, busy_d;

    logic              core_wins, dma_wins;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic [CTRL_W-1:0] sel_ctrl;
    logic              sel_err;
    logic              owner_rsp_ready;

    // Reject anything the memory must never see: out of range, reserved
    // encodings, unsigned stores and misaligned half/word accesses.
    function automatic logic req_illegal(input logic [ADDR_W-1:0] addr,
                                         input logic              we,
                                         input logic [CTRL_W-1:0] ctrl);
        logic bad_range, bad_ctrl, bad_store, bad_half, bad_word;
        bad_range = (addr >= ADDR_W'(ADDR_LIMIT));
        bad_ctrl  = (ctrl == 3'b011) || (ctrl == 3'b110) || (ctrl == 3'b111);
        bad_store = we && ((ctrl == 3'b100) || (ctrl == 3'b101));
        bad_half  = (ctrl[1:0] == 2'b01) && addr[0];
        bad_word  = (ctrl == 3'b010) && (addr[1:0] != 2'b00);
        return bad_range | bad_ctrl | bad_store | bad_half | bad_word;
    endfunction

    // Arbitration: last_grant points at the requester served most recently,
    // so on a tie the other one wins unless core has fixed priority.
    always_comb begin
        core_wins = core.req_valid &
                    (~dma.req_valid | FIXED_PRIO | (last_grant_q == OWNER_DMA));
        dma_wins  = dma.req_valid & ~core_wins;
        sel_addr  = dma_wins ? dma.req_addr  : core.req_addr;
        sel_wdata = dma_wins ? dma.req_wdata : core.req_wdata;
        sel_we    = dma_wins ? dma.req_we    : core.req_we;
        sel_ctrl  = dma_wins ? dma.req_ctrl  : core.req_ctrl;
        sel_err   = req_illegal(sel_addr, sel_we, sel_ctrl);
        owner_rsp_ready = (owner_q == OWNER_DMA) ? dma.rsp_ready : core.rsp_ready;
    end

    // Ready is only offered in IDLE and never while reset is asserted.
    assign core.req_ready = (state_q == IDLE) & rst_n & core_wins;
    assign dma.req_ready  = (state_q == IDLE) & rst_n & dma_wins;

    // Next-state and datapath register inputs.
    always_comb begin
        state_d          = state_q;
        last_grant_d     = last_grant_q;
        owner_d          = owner_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        we_d             = we_q;
        ctrl_d           = ctrl_q;
        err_d            = err_q;
        rsp_rdata_d      = rsp_rdata_q;
        rsp_err_d        = rsp_err_q;
        core_rsp_valid_d = core_rsp_valid_q;
        dma_rsp_valid_d  = dma_rsp_valid_q;

        unique case (state_q)
            IDLE: begin
                if (core_wins || dma_wins) begin
                    owner_d      = dma_wins;
                    last_grant_d = dma_wins;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    we_d         = sel_we;
                    ctrl_d       = sel_ctrl;
                    err_d        = sel_err;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                rsp_rdata_d      = (we_q | err_q) ? '0 : mem_read_data;
                rsp_err_d        = err_q;
                core_rsp_valid_d = (owner_q == OWNER_CORE);
                dma_rsp_valid_d  = (owner_q == OWNER_DMA);
                state_d          = RESP;
            end
            RESP: begin
                if (owner_rsp_ready) begin
                    core_rsp_valid_d = 1'b0;
                    dma_rsp_valid_d  = 1'b0;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            last_grant_q     <= OWNER_DMA;
            owner_q          <= OWNER_CORE;
            addr_q           <= '0;
            wdata_q          <= '0;
            we_q             <= 1'b0;
            ctrl_q           <= '0;
            err_q            <= 1'b0;
            rsp_rdata_q      <= '0;
            rsp_err_q        <= 1'b0;
            core_rsp_valid_q <= 1'b0;
            dma_rsp_valid_q  <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_grant_q     <= last_grant_d;
            owner_q          <= owner_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            we_q             <= we_d;
            ctrl_q           <= ctrl_d;
            err_q            <= err_d;
            rsp_rdata_q      <= rsp_rdata_d;
            rsp_err_q        <= rsp_err_d;
            core_rsp_valid_q <= core_rsp_valid_d;
            dma_rsp_valid_q  <= dma_rsp_valid_d;
            busy_q           <= busy_d;
        end
    end

    // Memory drive: only the ACCESS cycle touches the bus; rst_n gates the
    // write so a store caught by reset is dropped.
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = 1'b0;
        mem_dm_ctrl      = CTRL_IDLE;
        if (state_q == ACCESS) begin
            mem_address      = addr_q;
            mem_write_data   = wdata_q;
            mem_write_enable = we_q & ~err_q & rst_n;
            mem_dm_ctrl      = ctrl_q;
        end
    end

    assign core.rsp_valid = core_rsp_valid_q;
    assign core.rsp_rdata = rsp_rdata_q;
    assign core.rsp_err   = rsp_err_q;
    assign dma.rsp_valid  = dma_rsp_valid_q;
    assign dma.rsp_rdata  = rsp_rdata_q;
    assign dma.rsp_err    = rsp_err_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter (round-robin instance plus a
// fixed-priority instance used for the tie-break ordering).
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_arbiter_if core_if();
    dmem_arbiter_if dma_if();
    dmem_arbiter_if core_fp_if();
    dmem_arbiter_if dma_fp_if();

    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable, busy;
    logic [2:0]  mem_dm_ctrl;
    logic [31:0] fp_mem_address, fp_mem_write_data;
    logic        fp_mem_write_enable, fp_busy;
    logic [2:0]  fp_mem_dm_ctrl;

    dmem_arbiter #(.ADDR_LIMIT(256), .FIXED_PRIO(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .core(core_if), .dma(dma_if),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write_enable(mem_write_enable), .mem_dm_ctrl(mem_dm_ctrl),
        .mem_read_data(mem_read_data), .busy(busy)
    );

    dmem_arbiter #(.ADDR_LIMIT(256), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk(clk), .rst_n(rst_n), .core(core_fp_if), .dma(dma_fp_if),
        .mem_address(fp_mem_address), .mem_write_data(fp_mem_write_data),
        .mem_write_enable(fp_mem_write_enable), .mem_dm_ctrl(fp_mem_dm_ctrl),
        .mem_read_data(32'h0), .busy(fp_busy)
    );

    // Data memory model: 64 words, byte/half/word access, extended reads.
    logic [31:0] mem_arr [64];
    logic        mem_clr;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0;
        end else if (mem_write_enable) begin
            case (mem_dm_ctrl[1:0])
                2'b00:   mem_arr[mem_address[7:2]][{mem_address[1:0], 3'b000} +: 8] <= mem_write_data[7:0];
                2'b01:   mem_arr[mem_address[7:2]][{mem_address[1], 4'b0000} +: 16] <= mem_write_data[15:0];
                default: mem_arr[mem_address[7:2]] <= mem_write_data;
            endcase
        end
    end

    always_comb begin
        rd_word = mem_arr[mem_address[7:2]];
        rd_byte = rd_word[{mem_address[1:0], 3'b000} +: 8];
        rd_half = rd_word[{mem_address[1], 4'b0000} +: 16];
        case (mem_dm_ctrl)
            3'b000:  mem_read_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  mem_read_data = {24'h0, rd_byte};
            3'b001:  mem_read_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  mem_read_data = {16'h0, rd_half};
            default: mem_read_data = rd_word;
        endcase
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit is_dma, input logic v, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [2:0] ctrl);
        if (is_dma) begin
            dma_if.req_valid = v; dma_if.req_we = we; dma_if.req_addr = addr;
            dma_if.req_wdata = wdata; dma_if.req_ctrl = ctrl;
        end else begin
            core_if.req_valid = v; core_if.req_we = we; core_if.req_addr = addr;
            core_if.req_wdata = wdata; core_if.req_ctrl = ctrl;
        end
    endtask

    // One isolated transaction from IDLE, checked cycle by cycle.
    task automatic txn(input string tag, input bit is_dma, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ctrl, input logic [31:0] exp_rdata,
                       input logic exp_err);
        set_req(is_dma, 1'b1, we, addr, wdata, ctrl);
        #1;
        chk({tag, "_ready"}, is_dma ? dma_if.req_ready : core_if.req_ready, 32'd1);
        chk({tag, "_idle_we"}, mem_write_enable, 32'd0);
        step();
        set_req(is_dma, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        #1;
        chk({tag, "_acc_addr"}, mem_address, addr);
        chk({tag, "_acc_ctrl"}, mem_dm_ctrl, 32'(ctrl));
        chk({tag, "_acc_we"}, mem_write_enable, 32'(we & ~exp_err));
        chk({tag, "_acc_busy"}, busy, 32'd1);
        step();
        #1;
        chk({tag, "_rsp_valid"}, is_dma ? dma_if.rsp_valid : core_if.rsp_valid, 32'd1);
        chk({tag, "_rsp_rdata"}, is_dma ? dma_if.rsp_rdata : core_if.rsp_rdata, exp_rdata);
        chk({tag, "_rsp_err"}, is_dma ? dma_if.rsp_err : core_if.rsp_err, 32'(exp_err));
        chk({tag, "_rsp_we"}, mem_write_enable, 32'd0);
        step();
        #1;
        chk({tag, "_done_busy"}, busy, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        mem_clr = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        core_if.rsp_ready = 1'b1;
        dma_if.rsp_ready  = 1'b1;
        core_fp_if.req_valid = 1'b0; core_fp_if.req_we = 1'b0; core_fp_if.req_addr = 32'h0;
        core_fp_if.req_wdata = 32'h0; core_fp_if.req_ctrl = 3'b010; core_fp_if.rsp_ready = 1'b1;
        dma_fp_if.req_valid = 1'b0; dma_fp_if.req_we = 1'b0; dma_fp_if.req_addr = 32'h0;
        dma_fp_if.req_wdata = 32'h0; dma_fp_if.req_ctrl = 3'b010; dma_fp_if.rsp_ready = 1'b1;
        step();
        step();

        // Reset state; valid requests are ignored while rst_n is low.
        set_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        set_req(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        core_fp_if.req_valid = 1'b1;
        dma_fp_if.req_valid  = 1'b1;
        #1;
        chk("rst_busy", busy, 32'd0);
        chk("rst_core_rsp_valid", core_if.rsp_valid, 32'd0);
        chk("rst_dma_rsp_valid", dma_if.rsp_valid, 32'd0);
        chk("rst_rsp_rdata", core_if.rsp_rdata, 32'h0);
        chk("rst_rsp_err", core_if.rsp_err, 32'd0);
        chk("rst_core_ready", core_if.req_ready, 32'd0);
        chk("rst_dma_ready", dma_if.req_ready, 32'd0);
        chk("rst_dm_ctrl", mem_dm_ctrl, 32'd7);
        chk("rst_mem_we", mem_write_enable, 32'd0);
        step();
        rst_n = 1'b1;
        mem_clr = 1'b0;

        // Tie-break ordering with both requesters held valid.
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_core_ready", core_if.req_ready, 32'((i % 2) == 0));
            chk("rr_dma_ready", dma_if.req_ready, 32'((i % 2) == 1));
            chk("fp_core_ready", core_fp_if.req_ready, 32'd1);
            chk("fp_dma_ready", dma_fp_if.req_ready, 32'd0);
            step();
            step();
            step();
        end
        core_fp_if.req_valid = 1'b0;
        #1;
        chk("fp_dma_after_core_drop", dma_fp_if.req_ready, 32'd1);
        chk("fp_core_after_drop", core_fp_if.req_ready, 32'd0);
        chk("rr_core_fifth", core_if.req_ready, 32'd1);
        dma_fp_if.req_valid = 1'b0;
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        step();
        #1;
        chk("idle_after_drop_busy", busy, 32'd0);
        step();

        // Word load round trip.
        txn("dma_sw_w2", 1'b1, 1'b1, 32'h08, 32'h0000_0064, 3'b010, 32'h0, 1'b0);
        chk("mem_word2", mem_arr[2], 32'h0000_0064);
        txn("core_lw_08", 1'b0, 1'b0, 32'h08, 32'h0, 3'b010, 32'h0000_0064, 1'b0);

        // Byte store then unsigned/signed byte loads.
        txn("dma_sb_01", 1'b1, 1'b1, 32'h01, 32'h0000_00AA, 3'b000, 32'h0, 1'b0);
        chk("mem_word0", mem_arr[0], 32'h0000_AA00);
        txn("core_lbu_01", 1'b0, 1'b0, 32'h01, 32'h0, 3'b100, 32'h0000_00AA, 1'b0);
        txn("core_lb_01", 1'b0, 1'b0, 32'h01, 32'h0, 3'b000, 32'hFFFF_FFAA, 1'b0);
        txn("core_lh_00", 1'b0, 1'b0, 32'h00, 32'h0, 3'b001, 32'hFFFF_AA00, 1'b0);

        // Illegal requests never reach the memory write port.
        txn("err_core_sw_06", 1'b0, 1'b1, 32'h06, 32'h1111_1111, 3'b010, 32'h0, 1'b1);
        txn("err_core_lh_03", 1'b0, 1'b0, 32'h03, 32'h0, 3'b001, 32'h0, 1'b1);
        txn("err_dma_sw_100", 1'b1, 1'b1, 32'h100, 32'h2222_2222, 3'b010, 32'h0, 1'b1);
        txn("err_dma_st_bu", 1'b1, 1'b1, 32'h04, 32'hDEAD_BEEF, 3'b100, 32'h0, 1'b1);
        txn("err_core_ld_011", 1'b0, 1'b0, 32'h08, 32'h0, 3'b011, 32'h0, 1'b1);
        chk("mem_word1_untouched", mem_arr[1], 32'h0);

        // Response backpressure blocks the other requester.
        core_if.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 1'b0, 32'h08, 32'h0, 3'b010);
        #1;
        chk("bp_core_ready", core_if.req_ready, 32'd1);
        step();
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        set_req(1'b1, 1'b1, 1'b0, 32'h08, 32'h0, 3'b010);
        #1;
        chk("bp_dma_ready_access", dma_if.req_ready, 32'd0);
        step();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_core_rsp_valid", core_if.rsp_valid, 32'd1);
            chk("bp_core_rsp_rdata", core_if.rsp_rdata, 32'h0000_0064);
            chk("bp_dma_ready", dma_if.req_ready, 32'd0);
            chk("bp_dma_rsp_valid", dma_if.rsp_valid, 32'd0);
            step();
        end
        core_if.rsp_ready = 1'b1;
        #1;
        chk("bp_release_valid", core_if.rsp_valid, 32'd1);
        chk("bp_release_dma_ready", dma_if.req_ready, 32'd0);
        step();
        #1;
        chk("bp_idle_busy", busy, 32'd0);
        chk("bp_idle_dma_ready", dma_if.req_ready, 32'd1);
        chk("bp_idle_core_rsp", core_if.rsp_valid, 32'd0);
        step();
        set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        step();
        #1;
        chk("bp_dma_rsp_valid_end", dma_if.rsp_valid, 32'd1);
        chk("bp_dma_rsp_rdata_end", dma_if.rsp_rdata, 32'h0000_0064);
        step();

        // Reset during a store's ACCESS cycle drops it entirely.
        set_req(1'b0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 3'b010);
        #1;
        chk("rst_st_ready", core_if.req_ready, 32'd1);
        step();
        set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        rst_n = 1'b0;
        #1;
        chk("rst_st_mem_we", mem_write_enable, 32'd0);
        step();
        #1;
        chk("rst_st_busy", busy, 32'd0);
        chk("rst_st_rsp_valid", core_if.rsp_valid, 32'd0);
        chk("rst_st_word4", mem_arr[4], 32'h0);
        rst_n = 1'b1;
        step();
        #1;
        chk("rst_st_rsp_valid_later", core_if.rsp_valid, 32'd0);
        step();
        #1;
        chk("rst_st_busy_later", busy, 32'd0);
        chk("rst_st_word4_later", mem_arr[4], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
